pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Parametrised pipeline hazard controller for the in-order CPU core. It generalises the fixed single-source stall generator.
- Merges per-stage stall requests into one thermometer stall bus.
- Stretches load-use stalls over a programmable number of cycles.
- Sequences registered flush/redirect events for exceptions and branch recovery.
- Flags stuck pipelines with a sticky timeout. Sits between all pipeline stages and the PC/IF/ID/EX/MEM/WB register banks.

Parameters:
- N_STAGES, 6, stall bus width. Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- PC_W, 32, width of flush_pc/new_pc.
- LD_STAGE, 2, stage index stalled by a load-use hazard (ID).
- LD_HOLD, 1, stall cycles per ld_use_req pulse. Range 1..15.
- STALL_TIMEOUT, 1024, consecutive stall[0] cycles before stall_timeout sets. 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall_req  in  N_STAGES  level request; bit i set = stage i cannot advance
- ld_use_req  in  1  single-cycle pulse from ID on a load-use hazard
- flush_req  in  1  single-cycle request to flush and redirect
- flush_pc  in  PC_W  redirect target; sampled when flush_req=1
- stall  out  N_STAGES  per-stage hold enables; 1 = hold register
- flush  out  1  one-cycle flush of IF..MEM registers
- new_pc  out  PC_W  redirect PC; valid while flush=1
- hold_busy  out  1  load-use hold counter nonzero
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=1 at clk edge):
  - stall=0, flush=0, new_pc=0, hold_busy=0, stall_timeout=0.
  - Hold counter=0, timeout counter=0, FSM=IDLE.
  - Reset overrides every in-flight flush or hold.
- Effective request vector: eff = stall_req OR hold_vec.
  - hold_vec has bit LD_STAGE set while the hold counter is nonzero, or in the same cycle ld_use_req=1.
- Stall encoding is combinational, zero latency:
  - k = highest set index of eff; stall[k:0] all 1, stall[N-1:k+1] all 0.
  - eff=0 gives stall=0.
  - Example, N=6: request at ID gives 6'b000111; request at MEM gives 6'b011111.
- Hold counter, 4 bits:
  - ld_use_req=1 loads LD_HOLD-1 at the edge. The request cycle itself stalls, for LD_HOLD stall cycles in total.
  - The counter decrements each cycle while nonzero.
  - A new ld_use_req while nonzero reloads LD_HOLD-1 (no accumulation).
  - hold_busy = counter != 0.
- Flush FSM, states IDLE and FLUSH:
  - IDLE: flush_req=1 -> FLUSH at the next edge; new_pc <= flush_pc.
  - FLUSH: flush=1 for exactly this cycle.
    - flush_req=1 again: stay in FLUSH and recapture new_pc from flush_pc.
    - Otherwise -> IDLE; flush=0 and new_pc is held.
  - Latency: flush_req in cycle n gives flush=1 in cycle n+1.
- Flush priority:
  - In the FLUSH cycle stall is forced to 0, regardless of stall_req.
  - The hold counter is cleared in the FLUSH cycle.
  - ld_use_req arriving in the FLUSH cycle is ignored.
  - flush_req together with ld_use_req in IDLE: the hold loads, then is cleared in the following FLUSH cycle.
- Timeout watchdog:
  - The counter, width $clog2(STALL_TIMEOUT+1), increments while stall[0]=1.
  - It clears to 0 when stall[0]=0 and saturates at STALL_TIMEOUT.
  - When the count reaches STALL_TIMEOUT, stall_timeout is set at the next edge and stays set until rst.

Optional Feature:
- Macro: CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cyc[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cyc counts cycles with stall[0]=1.
  - perf_flush_cnt counts cycles with flush=1.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared defines header:
  - StallBus width macro, default 6.
  - Stage index constants: STG_PC=0, STG_IF=1, STG_ID=2, STG_EX=3, STG_MEM=4, STG_WB=5.
  - FSM state encodings: IDLE=1'b0, FLUSH=1'b1.
- One sub-module, stall_thermo_enc: a combinational highest-set-bit to thermometer encoder, parametrised by N_STAGES.

Test Plan (defaults, LD_HOLD=2 unless stated):
- Reset: rst=1 for 2 cycles with stall_req=6'b111111, then release with requests 0 -> all outputs 0 during reset and after release.
- Encoding: stall_req=6'b000100 gives stall=6'b000111; 6'b010001 gives 6'b011111; 6'b000000 gives 6'b000000, all in the same cycle.
- Load-use: ld_use_req pulse at cycle 10 with stall_req=0 -> stall=6'b000111 in cycles 10–11, 0 at 12; hold_busy=1 only in cycle 11.
- Flush during stall:
  - Stimulus: stall_req=6'b001000 held; flush_req=1 with flush_pc=32'hBFC00380 at cycle 20.
  - Cycle 21: flush=1, new_pc=BFC00380, stall=0.
  - Cycle 22: flush=0, stall=6'b001111.
- Back-to-back flush: flush_req in cycles 30 and 31 with PCs 0x100 and 0x200 -> flush=1 in cycles 31–32, new_pc=0x100 then 0x200.
- Timeout: STALL_TIMEOUT=8, stall_req[0] held for 9 cycles -> stall_timeout rises after the 9th cycle and stays high after the request drops, until rst.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg
//   Shared constants for the pipeline hazard controller: default stall bus
//   width, stage index constants and the flush sequencer state encoding.
//   STALL_BUS_W may be predefined by the build to change the default width.
`ifndef STALL_BUS_W
`define STALL_BUS_W 6
`endif

package pipe_stall_ctrl_pkg;

  localparam int DEF_STALL_BUS_W = `STALL_BUS_W;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if
//   Bundles the request and control signals between the pipeline stages and
//   the hazard controller.
//   master : pipeline side -- drives stall_req, ld_use_req, flush_req, flush_pc;
//            receives stall, flush, new_pc, hold_busy, stall_timeout.
//   slave  : controller side (opposite directions).
//   With CTRL_PERF_EN defined, perf_stall_cyc / perf_flush_cnt are added.
interface pipe_stall_ctrl_if
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int N_STAGES = DEF_STALL_BUS_W,
  parameter int PC_W     = 32
) ();

  logic [N_STAGES-1:0] stall_req;
  logic                ld_use_req;
  logic                flush_req;
  logic [PC_W-1:0]     flush_pc;
  logic [N_STAGES-1:0] stall;
  logic                flush;
  logic [PC_W-1:0]     new_pc;
  logic                hold_busy;
  logic                stall_timeout;
`ifdef CTRL_PERF_EN
  logic [31:0]         perf_stall_cyc;
  logic [31:0]         perf_flush_cnt;
`endif

  modport master (
    output stall_req, ld_use_req, flush_req, flush_pc,
`ifdef CTRL_PERF_EN
    input  perf_stall_cyc, perf_flush_cnt,
`endif
    input  stall, flush, new_pc, hold_busy, stall_timeout
  );

  modport slave (
    input  stall_req, ld_use_req, flush_req, flush_pc,
`ifdef CTRL_PERF_EN
    output perf_stall_cyc, perf_flush_cnt,
`endif
    output stall, flush, new_pc, hold_busy, stall_timeout
  );

endinterface

// File: rtl/pipe_stall_ctrl_thermo_enc.sv
// stall_thermo_enc
//   Combinational highest-set-bit to thermometer encoder. Every stage at or
//   below the most downstream requester is held, so no stage overruns a
//   stalled successor.
//   req   : per-stage request vector
//   therm : therm[i] = OR of req[N_STAGES-1:i]
module stall_thermo_enc #(
  parameter int N_STAGES = 6
) (
  input  logic [N_STAGES-1:0] req,
  output logic [N_STAGES-1:0] therm
);

  logic acc;

  always_comb begin
    acc   = 1'b0;
    therm = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      acc      = acc | req[i];
      therm[i] = acc;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Pipeline hazard controller: merges stall requests and a stretched
//   load-use hold into a thermometer stall bus, sequences one-cycle
//   flush/redirect events, and raises a sticky watchdog when stage 0 stays
//   stalled for STALL_TIMEOUT cycles (STALL_TIMEOUT=0 disables it).
//   Ports: clk, rst (synchronous, active-high), bus (pipe_stall_ctrl_if.slave).
//   Optional: CTRL_PERF_EN adds stall-cycle and flush-count perf counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int N_STAGES      = DEF_STALL_BUS_W,
  parameter int PC_W          = 32,
  parameter int LD_STAGE      = STG_ID,
  parameter int LD_HOLD       = 1,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
);

  localparam bit            TO_EN      = (STALL_TIMEOUT > 0);
  localparam int            TO_W       = TO_EN ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(STALL_TIMEOUT);
  localparam logic [3:0]    HOLD_RELOAD = 4'(LD_HOLD - 1);

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == TO_MAX) ? v : v + 1'b1;
  endfunction

  flush_state_e        state_q, state_d;
  logic [PC_W-1:0]     new_pc_q, new_pc_d;
  logic [3:0]          hold_q, hold_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                timeout_q, timeout_d;
  logic                flushing;
  logic [N_STAGES-1:0] hold_vec;
  logic [N_STAGES-1:0] eff;
  logic [N_STAGES-1:0] therm;
  logic [N_STAGES-1:0] stall;

  assign flushing = (state_q == ST_FLUSH);

  // Request merge: the load-use hold covers the request cycle itself, so the
  // live pulse is ORed in alongside the counter.
  always_comb begin
    hold_vec = '0;
    if (!rst && !flushing && ((hold_q != 4'd0) || bus.ld_use_req))
      hold_vec[LD_STAGE] = 1'b1;
    eff = bus.stall_req | hold_vec;
  end

  stall_thermo_enc #(.N_STAGES(N_STAGES)) u_enc (
    .req   (eff),
    .therm (therm)
  );

  // A flush cycle lets every stage load its bubble, so it wins over stalls.
  assign stall = (rst || flushing) ? '0 : therm;

  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush_req) begin
          state_d  = ST_FLUSH;
          new_pc_d = bus.flush_pc;
        end
      end
      ST_FLUSH: begin
        if (bus.flush_req) begin
          state_d  = ST_FLUSH;
          new_pc_d = bus.flush_pc;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reload rather than accumulate on overlapping load-use pulses.
  always_comb begin
    hold_d = hold_q;
    if (flushing)
      hold_d = 4'd0;
    else if (bus.ld_use_req)
      hold_d = HOLD_RELOAD;
    else if (hold_q != 4'd0)
      hold_d = hold_q - 4'd1;
  end

  always_comb begin
    to_cnt_d  = '0;
    timeout_d = 1'b0;
    if (TO_EN) begin
      to_cnt_d  = stall[STG_PC] ? sat_inc(to_cnt_q) : '0;
      timeout_d = timeout_q | (to_cnt_q == TO_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      new_pc_q  <= '0;
      hold_q    <= 4'd0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_pc_q  <= new_pc_d;
      hold_q    <= hold_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.stall         = stall;
  assign bus.flush         = flushing;
  assign bus.new_pc        = new_pc_q;
  assign bus.hold_busy     = (hold_q != 4'd0);
  assign bus.stall_timeout = timeout_q;

`ifdef CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall[STG_PC]};
    perf_flush_d = perf_flush_q + {31'd0, flushing};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign bus.perf_stall_cyc = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
//   Directed bench for pipe_stall_ctrl with LD_HOLD=2 and STALL_TIMEOUT=8.
//   Inputs change 1ns after each rising edge; outputs are sampled 4ns later.
module tb_pipe_stall_ctrl;

  localparam int N  = 6;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.N_STAGES(N), .PC_W(PW)) bus ();

  pipe_stall_ctrl #(
    .N_STAGES(N), .PC_W(PW), .LD_STAGE(2), .LD_HOLD(2), .STALL_TIMEOUT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".stall"}, 64'(bus.stall), 64'd0);
    chk({tag, ".flush"}, 64'(bus.flush), 64'd0);
    chk({tag, ".new_pc"}, 64'(bus.new_pc), 64'd0);
    chk({tag, ".hold_busy"}, 64'(bus.hold_busy), 64'd0);
    chk({tag, ".timeout"}, 64'(bus.stall_timeout), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.stall_req  = 6'b111111;
    bus.ld_use_req = 1'b0;
    bus.flush_req  = 1'b0;
    bus.flush_pc   = '0;

    // Reset held two cycles with all requests up
    next_cyc(); settle(); chk_idle("rst1");
    next_cyc(); settle(); chk_idle("rst2");
    next_cyc(); rst = 1'b0; bus.stall_req = '0; settle(); chk_idle("rel");

    // Combinational encoding
    next_cyc(); bus.stall_req = 6'b000100; settle();
    chk("enc_id", 64'(bus.stall), 64'b000111);
    next_cyc(); bus.stall_req = 6'b010001; settle();
    chk("enc_mem_pc", 64'(bus.stall), 64'b011111);
    next_cyc(); bus.stall_req = 6'b100000; settle();
    chk("enc_wb", 64'(bus.stall), 64'b111111);
    next_cyc(); bus.stall_req = 6'b000000; settle();
    chk("enc_none", 64'(bus.stall), 64'b000000);

    // Load-use hold of two cycles
    next_cyc(); bus.ld_use_req = 1'b1; settle();
    chk("ld0.stall", 64'(bus.stall), 64'b000111);
    chk("ld0.busy", 64'(bus.hold_busy), 64'd0);
    next_cyc(); bus.ld_use_req = 1'b0; settle();
    chk("ld1.stall", 64'(bus.stall), 64'b000111);
    chk("ld1.busy", 64'(bus.hold_busy), 64'd1);
    next_cyc(); settle();
    chk("ld2.stall", 64'(bus.stall), 64'b000000);
    chk("ld2.busy", 64'(bus.hold_busy), 64'd0);

    // Flush during an EX stall
    next_cyc(); bus.stall_req = 6'b001000; settle();
    chk("fs0.stall", 64'(bus.stall), 64'b001111);
    next_cyc(); bus.flush_req = 1'b1; bus.flush_pc = 32'hBFC00380; settle();
    chk("fs1.flush", 64'(bus.flush), 64'd0);
    chk("fs1.stall", 64'(bus.stall), 64'b001111);
    next_cyc(); bus.flush_req = 1'b0; settle();
    chk("fs2.flush", 64'(bus.flush), 64'd1);
    chk("fs2.new_pc", 64'(bus.new_pc), 64'hBFC00380);
    chk("fs2.stall", 64'(bus.stall), 64'd0);
    next_cyc(); settle();
    chk("fs3.flush", 64'(bus.flush), 64'd0);
    chk("fs3.stall", 64'(bus.stall), 64'b001111);
    chk("fs3.new_pc", 64'(bus.new_pc), 64'hBFC00380);
    next_cyc(); bus.stall_req = '0; settle();

    // Back-to-back flush; load-use in the flush cycle is ignored
    next_cyc(); bus.flush_req = 1'b1; bus.flush_pc = 32'h100; settle();
    next_cyc(); bus.flush_pc = 32'h200; settle();
    chk("bb1.flush", 64'(bus.flush), 64'd1);
    chk("bb1.new_pc", 64'(bus.new_pc), 64'h100);
    next_cyc(); bus.flush_req = 1'b0; bus.ld_use_req = 1'b1; settle();
    chk("bb2.flush", 64'(bus.flush), 64'd1);
    chk("bb2.new_pc", 64'(bus.new_pc), 64'h200);
    chk("bb2.stall", 64'(bus.stall), 64'd0);
    next_cyc(); bus.ld_use_req = 1'b0; settle();
    chk("bb3.flush", 64'(bus.flush), 64'd0);
    chk("bb3.busy", 64'(bus.hold_busy), 64'd0);
    chk("bb3.stall", 64'(bus.stall), 64'd0);
    chk("bb3.new_pc", 64'(bus.new_pc), 64'h200);

    // flush_req together with ld_use_req in IDLE
    next_cyc(); bus.flush_req = 1'b1; bus.ld_use_req = 1'b1; bus.flush_pc = 32'h300; settle();
    chk("fl0.stall", 64'(bus.stall), 64'b000111);
    next_cyc(); bus.flush_req = 1'b0; bus.ld_use_req = 1'b0; settle();
    chk("fl1.flush", 64'(bus.flush), 64'd1);
    chk("fl1.stall", 64'(bus.stall), 64'd0);
    chk("fl1.busy", 64'(bus.hold_busy), 64'd1);
    next_cyc(); settle();
    chk("fl2.busy", 64'(bus.hold_busy), 64'd0);
    chk("fl2.stall", 64'(bus.stall), 64'd0);
    chk("fl2.timeout", 64'(bus.stall_timeout), 64'd0);

    // Watchdog: stage 0 stalled for nine cycles
    next_cyc(); rst = 1'b1; settle();
    next_cyc(); rst = 1'b0; settle();
    chk("to_rst", 64'(bus.stall_timeout), 64'd0);
    for (int i = 1; i <= 9; i++) begin
      next_cyc(); bus.stall_req = 6'b000001; settle();
      if (i >= 8) chk($sformatf("to_c%0d", i), 64'(bus.stall_timeout), 64'd0);
    end
    next_cyc(); bus.stall_req = '0; settle();
    chk("to_set", 64'(bus.stall_timeout), 64'd1);
    next_cyc(); settle(); next_cyc(); settle();
    chk("to_sticky", 64'(bus.stall_timeout), 64'd1);
    next_cyc(); rst = 1'b1; settle();
    next_cyc(); rst = 1'b0; settle();
    chk("to_clr", 64'(bus.stall_timeout), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
